// File: rtl/main_memory_fill_responder.sv
// Memory-side responder for cache line fills. After a fixed access latency it returns one
// aligned line of BURST_LEN words, streamed beat by beat under valid/ready flow control.
module main_memory_fill_responder #(
  parameter int DEPTH     = 1024,
  parameter int BURST_LEN = 4,
  parameter int LATENCY   = 3,
  parameter int WORD_W    = 64
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [31:0]                  req_addr,
  output logic                         resp_valid,
  input  logic                         resp_ready,
  output logic [WORD_W-1:0]            resp_data,
  output logic [$clog2(BURST_LEN)-1:0] resp_idx,
  output logic                         resp_last,
  input  logic                         load_en,
  input  logic [31:0]                  load_addr,
  input  logic [WORD_W-1:0]            load_data,
  output logic                         load_ready
);

  localparam int IDX_W  = $clog2(DEPTH);
  localparam int OFF_W  = $clog2(BURST_LEN);
  localparam int LINE_W = IDX_W - OFF_W;
  localparam int LAT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    SEND = 2'd2
  } state_t;

  state_t              state_reg, state_next;
  logic [LAT_W-1:0]    lat_cnt_reg, lat_cnt_next;
  logic [LINE_W-1:0]   line_reg, line_next;
  logic [OFF_W-1:0]    beat_reg, beat_next;
  logic                resp_valid_reg, resp_valid_next;
  logic                resp_last_reg, resp_last_next;
  logic                req_ready_reg, req_ready_next;
  logic [WORD_W-1:0]   resp_data_reg;
  logic                rd_en;
  logic [OFF_W-1:0]    rd_beat;
  logic [IDX_W-1:0]    rd_addr;
  logic                unused_addr_bits;

  logic [WORD_W-1:0]   mem [DEPTH];

  // Only the in-array index matters; everything above it aliases.
  assign unused_addr_bits = ^{req_addr[31:IDX_W], req_addr[OFF_W-1:0], load_addr[31:IDX_W]};

  assign rd_addr = {line_reg, rd_beat};

  // Array write port: only while idle, and never while reset is held.
  always_ff @(posedge clock) begin
    if (!reset && load_en && req_ready_reg) begin
      mem[load_addr[IDX_W-1:0]] <= load_data;
    end
  end

  // Registered read doubles as the beat output register.
  always_ff @(posedge clock) begin
    if (reset) begin
      resp_data_reg <= '0;
    end else if (rd_en) begin
      resp_data_reg <= mem[rd_addr];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= IDLE;
      lat_cnt_reg    <= '0;
      line_reg       <= '0;
      beat_reg       <= '0;
      resp_valid_reg <= 1'b0;
      resp_last_reg  <= 1'b0;
      req_ready_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      lat_cnt_reg    <= lat_cnt_next;
      line_reg       <= line_next;
      beat_reg       <= beat_next;
      resp_valid_reg <= resp_valid_next;
      resp_last_reg  <= resp_last_next;
      req_ready_reg  <= req_ready_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    lat_cnt_next    = lat_cnt_reg;
    line_next       = line_reg;
    beat_next       = beat_reg;
    resp_valid_next = resp_valid_reg;
    resp_last_next  = resp_last_reg;
    rd_en           = 1'b0;
    rd_beat         = beat_reg;

    case (state_reg)
      IDLE: begin
        if (req_valid && req_ready_reg) begin
          line_next    = req_addr[IDX_W-1:OFF_W];
          lat_cnt_next = LAT_W'(LATENCY - 1);
          state_next   = WAIT;
        end
      end
      WAIT: begin
        if (lat_cnt_reg == '0) begin
          rd_en           = 1'b1;
          rd_beat         = '0;
          beat_next       = '0;
          resp_valid_next = 1'b1;
          resp_last_next  = 1'b0;
          state_next      = SEND;
        end else begin
          lat_cnt_next = lat_cnt_reg - LAT_W'(1);
        end
      end
      SEND: begin
        if (resp_ready) begin
          if (beat_reg == OFF_W'(BURST_LEN - 1)) begin
            resp_valid_next = 1'b0;
            resp_last_next  = 1'b0;
            beat_next       = '0;
            state_next      = IDLE;
          end else begin
            rd_en          = 1'b1;
            rd_beat        = beat_reg + OFF_W'(1);
            beat_next      = beat_reg + OFF_W'(1);
            resp_last_next = (beat_reg + OFF_W'(1)) == OFF_W'(BURST_LEN - 1);
          end
        end
      end
      default: begin
        state_next      = IDLE;
        resp_valid_next = 1'b0;
        resp_last_next  = 1'b0;
        beat_next       = '0;
      end
    endcase

    req_ready_next = (state_next == IDLE);
  end

  assign req_ready  = req_ready_reg;
  assign load_ready = req_ready_reg;
  assign resp_valid = resp_valid_reg;
  assign resp_last  = resp_last_reg;
  assign resp_idx   = beat_reg;
  assign resp_data  = resp_data_reg;

endmodule

// File: tb/tb_main_memory_fill_responder.sv
// Bench for main_memory_fill_responder: directed and randomized bursts checked against a
// shadow copy of the array and the latency/ordering rules of a line fill.
module tb_main_memory_fill_responder;

  localparam int DEPTH   = 1024;
  localparam int BL      = 4;
  localparam int LATENCY = 3;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_data;
  logic [1:0]  resp_idx;
  logic        resp_last;
  logic        load_en;
  logic [31:0] load_addr;
  logic [63:0] load_data;
  logic        load_ready;

  logic [63:0] model [DEPTH];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  main_memory_fill_responder #(
    .DEPTH(DEPTH), .BURST_LEN(BL), .LATENCY(LATENCY), .WORD_W(64)
  ) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_idx(resp_idx), .resp_last(resp_last),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .load_ready(load_ready)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One load through the port while idle; upper address bits randomized to exercise aliasing.
  task automatic do_load(input int idx, input logic [63:0] data);
    load_en   = 1'b1;
    load_addr = 32'(idx) | ({$urandom_range(3)} << 10);
    load_data = data;
    check("load_ready", 64'(load_ready), 64'd1);
    @(negedge clock);
    load_en = 1'b0;
    model[idx % DEPTH] = data;
  endtask

  // One fill request; every beat is checked against the shadow array.
  task automatic do_burst(input logic [31:0] addr, input int stall_pct, input int hold1,
                          input bit poke, input bit abort,
                          input bit ld_with_req, input int ld_idx, input logic [63:0] ld_val);
    int  base, k, n, first_n, held;
    bit  rdy, poked;
    base = int'(addr % DEPTH) & ~(BL - 1);
    k = 0; n = 0; first_n = -1; held = 0; poked = 0;
    check("req_ready_before", 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req_addr  = addr;
    if (ld_with_req) begin
      load_en = 1'b1; load_addr = 32'(ld_idx); load_data = ld_val;
      model[ld_idx % DEPTH] = ld_val;
    end
    @(negedge clock);
    req_valid = 1'b0; load_en = 1'b0; req_addr = $urandom;
    while (k < BL && n < 200) begin
      if (resp_valid) begin
        if (first_n < 0) begin
          first_n = n;
          check("latency", 64'(n), 64'(LATENCY));
        end
        check("beat_data", resp_data, model[base + k]);
        check("beat_idx", 64'(resp_idx), 64'(k));
        check("beat_last", 64'(resp_last), 64'(k == BL - 1));
        check("req_ready_busy", 64'(req_ready), 64'd0);
        if (abort && k == 2) begin
          reset = 1'b1;
          @(negedge clock);
          check("abort_valid", 64'(resp_valid), 64'd0);
          check("abort_idx", 64'(resp_idx), 64'd0);
          check("abort_last", 64'(resp_last), 64'd0);
          check("abort_data", resp_data, 64'd0);
          check("abort_ready", 64'(req_ready), 64'd0);
          reset = 1'b0;
          resp_ready = 1'b0;
          @(negedge clock);
          check("abort_rearm", 64'(req_ready), 64'd1);
          check("abort_quiet", 64'(resp_valid), 64'd0);
          $display("burst addr=%08h aborted at beat 2", addr);
          return;
        end
        if (poke && k == 1 && !poked) begin
          poked = 1;
          load_en = 1'b1; load_addr = 32'(base + 2); load_data = {$urandom, $urandom};
          check("load_ready_busy", 64'(load_ready), 64'd0);
        end
        rdy = ($urandom_range(99) >= stall_pct);
        if (k == 1 && held < hold1) begin
          rdy = 1'b0;
          held++;
        end
        resp_ready = rdy;
        if (rdy) k++;
      end else begin
        check("idle_idx", 64'(resp_idx), 64'd0);
        check("idle_last", 64'(resp_last), 64'd0);
        resp_ready = 1'($urandom_range(1));
      end
      @(negedge clock);
      load_en = 1'b0;
      n++;
    end
    resp_ready = 1'b0;
    check("burst_beats", 64'(k), 64'(BL));
    check("end_valid", 64'(resp_valid), 64'd0);
    check("end_ready", 64'(req_ready), 64'd1);
    if (stall_pct == 0 && hold1 == 0) check("burst_cycles", 64'(n), 64'(LATENCY + BL));
    $display("burst addr=%08h base=%03h beats=%0d cycles=%0d", addr, base, k, n);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_addr = '0; resp_ready = 1'b0;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    repeat (3) @(negedge clock);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_load_ready", 64'(load_ready), 64'd0);
    check("rst_valid", 64'(resp_valid), 64'd0);
    check("rst_idx", 64'(resp_idx), 64'd0);
    check("rst_last", 64'(resp_last), 64'd0);
    check("rst_data", resp_data, 64'd0);
    reset = 1'b0;
    @(negedge clock);
    check("post_rst_ready", 64'(req_ready), 64'd1);
    for (int i = 0; i < 8; i++) begin
      resp_ready = 1'($urandom_range(1));
      @(negedge clock);
      check("no_spurious_beat", 64'(resp_valid), 64'd0);
    end
    resp_ready = 1'b0;

    // Preload: i*i+1 for the first 16 words, random data elsewhere in use.
    for (int i = 0; i < 16; i++) do_load(i, 64'(i * i + 1));
    for (int i = 16; i < 256; i++) do_load(i, {$urandom, $urandom});
    for (int i = 'h3FC; i < 'h400; i++) do_load(i, {$urandom, $urandom});
    check("preload_6", model[6], 64'd37);

    // Nominal, backpressure, alias and top-of-array bursts.
    do_burst(32'h6, 0, 0, 0, 0, 0, 0, '0);
    do_burst(32'h6, 0, 5, 0, 0, 0, 0, '0);
    do_burst(32'h403, 0, 0, 0, 0, 0, 0, '0);
    do_burst(32'h3FF, 0, 0, 0, 0, 0, 0, '0);

    // Same-edge load + request, then a load dropped during SEND.
    do_burst(32'h8, 0, 0, 0, 0, 1, 9, 64'hDEAD);
    check("same_edge_model", model[9], 64'hDEAD);
    do_burst(32'h8, 20, 0, 1, 0, 0, 0, '0);
    do_burst(32'h8, 0, 0, 0, 0, 0, 0, '0);

    // Reset mid-burst, then the same line again in full.
    do_burst(32'h24, 0, 0, 0, 1, 0, 0, '0);
    do_burst(32'h24, 0, 0, 0, 0, 0, 0, '0);

    // Randomized bursts with random stalls and interleaved loads.
    for (int t = 0; t < 24; t++) begin
      if ($urandom_range(1) == 1) do_load($urandom_range(255), {$urandom, $urandom});
      do_burst(32'($urandom_range(255)) | ({$urandom} << 10), 30, 0, 0, 0,
               1'($urandom_range(1)), $urandom_range(255), {$urandom, $urandom});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
